toggle_handshake_rx: RTL and testbench

Receiving end of a toggle-based, two-phase request/acknowledge link for crossing a word from an unrelated clock domain into `clk`. The sender flips a toggle-flop request line after placing data on a held-stable bus. This block synchronizes the toggle, captures the word into a one-entry output buffer and returns an acknowledge toggle. Downstream logic drains the buffer through a valid/ready interface. The block applies backpressure to the sender by withholding the acknowledge while the buffer is occupied.

---
 rtl/toggle_handshake_rx.sv | 90 +++++++++
 tb/tb_toggle_handshake_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle req/ack link: synchronizes req_tgl, captures
// the held-stable sender word into a one-entry buffer and drains it by valid/ready.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  // Encoding chosen so out_valid and busy fall straight out of the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    STALL = 2'b11
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   pend;
  logic                   capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], req_tgl};
  end

  assign req_s = sync[SYNC_STAGES-1];
  assign pend  = req_s ^ ack_tgl;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      EMPTY: begin
        if (pend) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready && pend) begin
          capture = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end else if (pend) begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        // Ack was withheld, so the sender is still holding req_data for us.
        if (out_ready) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      ack_tgl    <= 1'b0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        out_data   <= req_data;
        ack_tgl    <= ~ack_tgl;
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  assign out_valid = state[0];
  assign busy      = state[1];

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed and randomized checks of toggle_handshake_rx against a queue-based
// sender/receiver reference model.
module tb_toggle_handshake_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_tgl = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        ack_tgl;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] xfer_count;

  int errors = 0;
  int checks = 0;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .xfer_count(xfer_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_tgl = 1'b0; req_data = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sender with a 2-flop ack synchronizer plus a downstream sink; every word sent
  // is queued and must come out exactly once, in order.
  task automatic run_stream(input int n, input bit rnd);
    logic [7:0] q[$];
    logic [7:0] w, hdata;
    logic       as1, as2, last_ack;
    bit         hold, done;
    int         sent, acks, dly, budget;
    sent = 0; acks = 0; dly = 0; budget = 0; hold = 0; done = 0;
    as1 = ack_tgl; as2 = ack_tgl; last_ack = ack_tgl; hdata = 8'h00;
    while (!done && budget < 90000) begin
      step();
      budget++;
      if (ack_tgl !== last_ack) begin
        acks++;
        last_ack = ack_tgl;
        chk("ack_not_ahead", 32'(acks <= sent), 32'd1);
      end
      if (hold) begin
        chk("stall_data", 32'(out_data), 32'(hdata));
        chk("stall_valid", 32'(out_valid), 32'd1);
      end
      as2 = as1; as1 = ack_tgl;
      if (sent < n && as2 == req_tgl) begin
        if (dly > 0) dly--;
        else begin
          w = rnd ? 8'($urandom) : 8'(sent);
          req_data = w;
          req_tgl  = ~req_tgl;
          q.push_back(w);
          sent++;
          dly = (rnd && $urandom_range(0, 3) == 0) ? 1 : 0;
        end
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        chk("word_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("word", 32'(out_data), 32'(q.pop_front()));
      end
      hold  = out_valid && !out_ready;
      hdata = out_data;
      done  = (sent == n) && (q.size() == 0) && (as2 == req_tgl);
    end
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_acks", 32'(acks), 32'(n));
    chk("stream_count", 32'(xfer_count), 32'(n % 65536));
    out_ready = 1'b0;
  endtask

  initial begin
    // 1. reset sequence
    do_reset();
    step();
    #4 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack_tgl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // 2. single transfer, capture two edges after the first sampling edge
    do_reset();
    req_data = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
    step(); chk("single_e0_valid", 32'(out_valid), 32'd0);
    step(); chk("single_e1_valid", 32'(out_valid), 32'd0);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_ack", 32'(ack_tgl), 32'd1);
    chk("single_count", 32'(xfer_count), 32'd1);
    step();
    chk("single_drain", 32'(out_valid), 32'd0);

    // 3. backpressure: second word stalls until one ready cycle
    do_reset();
    req_data = 8'h11; req_tgl = 1'b1;
    for (int i = 0; i < 10 && ack_tgl !== 1'b1; i++) step();
    chk("bp_ack1", 32'(ack_tgl), 32'd1);
    chk("bp_data1", 32'(out_data), 32'h11);
    req_data = 8'h22; req_tgl = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_ack_held", 32'(ack_tgl), 32'd1);
    chk("bp_data_held", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_data", 32'(out_data), 32'h22);
    chk("bp_rel_valid", 32'(out_valid), 32'd1);
    chk("bp_rel_ack", 32'(ack_tgl), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk("bp_rel_count", 32'(xfer_count), 32'd2);

    // 4. back-to-back stream 0x00..0xFF
    do_reset();
    run_stream(256, 1'b0);

    // 5. reset while stalled
    do_reset();
    req_data = 8'h33; req_tgl = 1'b1;
    for (int i = 0; i < 10 && ack_tgl !== 1'b1; i++) step();
    req_data = 8'h44; req_tgl = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stall_busy", 32'(busy), 32'd1);
    #4 rst = 1'b1;
    #1;
    chk("stall_rst_valid", 32'(out_valid), 32'd0);
    chk("stall_rst_busy", 32'(busy), 32'd0);
    chk("stall_rst_ack", 32'(ack_tgl), 32'd0);
    req_tgl = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_post_valid", 32'(out_valid), 32'd0);
    end
    chk("stall_post_count", 32'(xfer_count), 32'd0);

    // 6. random ready and sender delays
    do_reset();
    run_stream(10000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
